// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the icache and dcache.
// One 128-bit line transaction at a time; the command is latched at grant and the line is routed back on completion.
module mem_arbiter #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic                  i_op,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [LINE_WIDTH-1:0] i_data_in,
  output logic [LINE_WIDTH-1:0] i_data_out,
  output logic                  i_ready,
  input  logic                  d_req,
  input  logic                  d_op,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_data_in,
  output logic [LINE_WIDTH-1:0] d_data_out,
  output logic                  d_ready,
  output logic                  mem_enable,
  output logic                  mem_op_init,
  output logic                  mem_op,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_data_in,
  output logic                  mem_op_done,
  input  logic [LINE_WIDTH-1:0] mem_data_out,
  input  logic                  mem_data_ready,
  input  logic                  memory_in_use,
  output logic                  busy,
  output logic                  grant_d
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t state_r;
  logic   last_grant_r;
  logic   start_s;
  logic   pick_d_s;

  // Grant decision: on a tie the port not served last wins.
  always_comb begin
    start_s  = 1'b0;
    pick_d_s = 1'b0;
    if ((state_r == S_IDLE) && !memory_in_use && (i_req || d_req)) begin
      start_s  = 1'b1;
      pick_d_s = d_req && (!i_req || !last_grant_r);
    end else begin
      start_s  = 1'b0;
      pick_d_s = 1'b0;
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      last_grant_r <= 1'b1;
      mem_enable   <= 1'b0;
      mem_op_init  <= 1'b0;
      mem_op       <= 1'b0;
      mem_address  <= {ADDR_WIDTH{1'b0}};
      mem_data_in  <= {LINE_WIDTH{1'b0}};
      mem_op_done  <= 1'b0;
      i_ready      <= 1'b0;
      d_ready      <= 1'b0;
      i_data_out   <= {LINE_WIDTH{1'b0}};
      d_data_out   <= {LINE_WIDTH{1'b0}};
      busy         <= 1'b0;
      grant_d      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_s) begin
            state_r      <= S_ISSUE;
            mem_enable   <= 1'b1;
            mem_op_init  <= 1'b1;
            busy         <= 1'b1;
            grant_d      <= pick_d_s;
            last_grant_r <= pick_d_s;
            mem_op       <= pick_d_s ? d_op      : i_op;
            mem_address  <= pick_d_s ? d_address : i_address;
            mem_data_in  <= pick_d_s ? d_data_in : i_data_in;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ISSUE: begin
          state_r     <= S_WAIT;
          mem_op_init <= 1'b0;
        end
        S_WAIT: begin
          if (mem_data_ready) begin
            state_r     <= S_RESPOND;
            mem_enable  <= 1'b0;
            mem_op_done <= 1'b1;
            if (grant_d) begin
              d_data_out <= mem_data_out;
              d_ready    <= 1'b1;
            end else begin
              i_data_out <= mem_data_out;
              i_ready    <= 1'b1;
            end
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_RESPOND: begin
          state_r     <= S_IDLE;
          mem_op_done <= 1'b0;
          i_ready     <= 1'b0;
          d_ready     <= 1'b0;
          busy        <= 1'b0;
        end
        default: begin
          state_r     <= S_IDLE;
          mem_enable  <= 1'b0;
          mem_op_init <= 1'b0;
          mem_op_done <= 1'b0;
          i_ready     <= 1'b0;
          d_ready     <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized transactions against a transaction-level model of mem_arbiter.
// The model tracks the round-robin owner and the last line delivered to each cache.
module tb_mem_arbiter;

  localparam int LW = 128;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_op, d_req, d_op;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] i_data_in, d_data_in;
  logic [LW-1:0] i_data_out, d_data_out;
  logic          i_ready, d_ready;
  logic          mem_enable, mem_op_init, mem_op, mem_op_done;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_data_in, mem_data_out;
  logic          mem_data_ready, memory_in_use;
  logic          busy, grant_d;

  int checks = 0;
  int errors = 0;

  bit            exp_last;
  logic [LW-1:0] exp_i;
  logic [LW-1:0] exp_d;

  mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_op(i_op), .i_address(i_address), .i_data_in(i_data_in),
    .i_data_out(i_data_out), .i_ready(i_ready),
    .d_req(d_req), .d_op(d_op), .d_address(d_address), .d_data_in(d_data_in),
    .d_data_out(d_data_out), .d_ready(d_ready),
    .mem_enable(mem_enable), .mem_op_init(mem_op_init), .mem_op(mem_op),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_op_done(mem_op_done),
    .mem_data_out(mem_data_out), .mem_data_ready(mem_data_ready),
    .memory_in_use(memory_in_use), .busy(busy), .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_lines(input string tag);
    chk({tag, "_iout"}, i_data_out, exp_i);
    chk({tag, "_dout"}, d_data_out, exp_d);
  endtask

  // One full transaction: optional busy-memory stall, grant, WAIT of lat cycles, then respond or abort by reset.
  task automatic run_txn(input bit ireq, input bit dreq, input int lat, input int busy_cyc, input bit abort);
    bit            win_d;
    bit            eop;
    logic [AW-1:0] eaddr;
    logic [LW-1:0] ewd;
    logic [LW-1:0] line;
    i_op      = 1'($urandom);
    d_op      = 1'($urandom);
    i_address = AW'($urandom);
    d_address = AW'($urandom);
    i_data_in = rand_line();
    d_data_in = rand_line();
    i_req     = ireq;
    d_req     = dreq;
    win_d     = (ireq && dreq) ? !exp_last : dreq;
    eop       = win_d ? d_op : i_op;
    eaddr     = win_d ? d_address : i_address;
    ewd       = win_d ? d_data_in : i_data_in;
    if (busy_cyc > 0) begin
      memory_in_use = 1'b1;
      for (int c = 0; c < busy_cyc; c++) begin
        mem_data_ready = 1'($urandom);
        step();
        chk("inuse_idle", 128'({busy, mem_op_init, mem_enable, i_ready, d_ready}), 128'(5'b0));
        chk_lines("inuse");
      end
      memory_in_use  = 1'b0;
      mem_data_ready = 1'b0;
    end
    step();
    exp_last = win_d;
    chk("issue_ctl", 128'({busy, mem_enable, mem_op_init, mem_op_done}), 128'(4'b1110));
    chk("issue_grant", 128'(grant_d), 128'(win_d));
    chk("issue_addr", 128'(mem_address), 128'(eaddr));
    chk("issue_op", 128'(mem_op), 128'(eop));
    chk("issue_wdata", mem_data_in, ewd);
    i_req     = 1'b0;
    d_req     = 1'b0;
    i_address = AW'($urandom);
    d_address = AW'($urandom);
    i_data_in = rand_line();
    d_data_in = rand_line();
    i_op      = ~i_op;
    d_op      = ~d_op;
    step();
    chk("wait_ctl", 128'({busy, mem_enable, mem_op_init, mem_op_done}), 128'(4'b1100));
    for (int c = 1; c < lat; c++) begin
      i_address = AW'($urandom);
      d_address = AW'($urandom);
      step();
      chk("wait_hold", 128'({busy, mem_enable, mem_op_init, mem_op_done, i_ready, d_ready}), 128'(6'b110000));
      chk("wait_addr", 128'(mem_address), 128'(eaddr));
    end
    if (abort) begin
      reset          = 1'b1;
      mem_data_ready = 1'b1;
      mem_data_out   = rand_line();
      step();
      reset    = 1'b0;
      exp_last = 1'b1;
      exp_i    = '0;
      exp_d    = '0;
      chk("abort_ctl", 128'({busy, mem_enable, mem_op_init, mem_op_done, i_ready, d_ready, grant_d}), 128'(7'b0));
      chk("abort_addr", 128'(mem_address), 128'(12'h000));
      chk_lines("abort");
      step();
      chk("abort_idle", 128'({busy, mem_enable, mem_op_init, mem_op_done, i_ready, d_ready}), 128'(6'b0));
      chk_lines("abort_idle");
      mem_data_ready = 1'b0;
    end else begin
      line           = rand_line();
      mem_data_out   = line;
      mem_data_ready = 1'b1;
      step();
      mem_data_ready = 1'b0;
      mem_data_out   = rand_line();
      if (win_d) exp_d = line;
      else       exp_i = line;
      chk("rsp_ctl", 128'({busy, mem_enable, mem_op_init, mem_op_done}), 128'(4'b1001));
      chk("rsp_ready", 128'({i_ready, d_ready}), 128'({!win_d, win_d}));
      chk("rsp_addr", 128'(mem_address), 128'(eaddr));
      chk("rsp_wdata", mem_data_in, ewd);
      chk_lines("rsp");
      step();
      chk("idle_ctl", 128'({busy, mem_enable, mem_op_init, mem_op_done, i_ready, d_ready}), 128'(6'b0));
      chk("idle_grant", 128'(grant_d), 128'(win_d));
      chk_lines("idle");
    end
  endtask

  initial begin
    int r;
    reset          = 1'b1;
    i_req          = 1'b1;
    d_req          = 1'b1;
    i_op           = 1'b0;
    d_op           = 1'b0;
    i_address      = '0;
    d_address      = '0;
    i_data_in      = '0;
    d_data_in      = '0;
    mem_data_out   = '0;
    mem_data_ready = 1'b0;
    memory_in_use  = 1'b0;
    exp_last       = 1'b1;
    exp_i          = '0;
    exp_d          = '0;
    step();
    step();
    chk("rst_ctl", 128'({mem_enable, mem_op_init, mem_op, mem_op_done, i_ready, d_ready, busy, grant_d}), 128'(8'b0));
    chk("rst_addr", 128'(mem_address), 128'(12'h000));
    chk("rst_wdata", mem_data_in, 128'h0);
    chk_lines("rst");
    reset = 1'b0;

    run_txn(1'b1, 1'b1, 1, 0, 1'b0);
    run_txn(1'b1, 1'b0, 5, 0, 1'b0);
    for (int t = 0; t < 4; t++) run_txn(1'b1, 1'b1, int'($urandom_range(1, 4)), 0, 1'b0);
    run_txn(1'b0, 1'b1, 2, 4, 1'b0);
    run_txn(1'b0, 1'b1, 3, 0, 1'b0);
    run_txn(1'b1, 1'b0, 3, 0, 1'b1);
    run_txn(1'b1, 1'b1, 2, 0, 1'b0);
    run_txn(1'b0, 1'b1, 4, 0, 1'b1);
    run_txn(1'b0, 1'b1, 1, 0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      r = int'($urandom_range(1, 3));
      run_txn(r[0], r[1], int'($urandom_range(1, 6)), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
